heaa_pipe_adder: RTL and testbench



---
 rtl/heaa_pipe_adder.sv | 182 ++++++++++++++++++
 tb/tb_heaa_pipe_adder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/heaa_pipe_adder.sv
// heaa_pipe_adder: pipelined hybrid error-tolerant approximate adder.
//
// The low n 4-bit groups of the operands are summed with bitwise OR. The remaining
// groups are summed exactly with 4-bit carry-lookahead blocks. The carry into the
// first exact group is predicted from the top inexact bit pair. GPS groups are
// resolved per pipeline stage. All stages advance together unless the output
// register holds a result that downstream has not taken.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous, active-high reset
//   in_valid_i     operand transfer request
//   in_ready_o     operands accepted this cycle (combinational on out_ready_i)
//   a_i, b_i       operands
//   inacc_sel_i    number of inexact 4-bit groups (clamped to MAX_INACC/4)
//   out_valid_o    result available (registered)
//   out_ready_i    downstream accepts result
//   sum_o          result; MSB is the final carry out (registered)
//   approx_hit_o   low part of this result may differ from the exact sum (registered)
//   hit_count_o    saturating count of delivered results with approx_hit_o=1
//   clr_count_i    synchronous clear of hit_count_o (wins over an increment)
module heaa_pipe_adder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_INACC = 16,
  parameter int unsigned GPS       = 2,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [WIDTH-1:0]                     a_i,
  input  logic [WIDTH-1:0]                     b_i,
  input  logic [$clog2(MAX_INACC/4+1)-1:0]     inacc_sel_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [WIDTH:0]                       sum_o,
  output logic                                 approx_hit_o,
  output logic [COUNT_W-1:0]                   hit_count_o,
  input  logic                                 clr_count_i
);

  localparam int unsigned G    = WIDTH / 4;
  localparam int unsigned LAT  = (G + GPS - 1) / GPS;
  localparam int unsigned NMax = MAX_INACC / 4;
  localparam int unsigned SelW = $clog2(MAX_INACC / 4 + 1);

  // Exact 4-bit carry-lookahead block: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  // Stage registers; index LAT-1 is the output register.
  logic [LAT-1:0]            st_valid_q, st_valid_d;
  logic [LAT-1:0][WIDTH-1:0] st_a_q, st_a_d;
  logic [LAT-1:0][WIDTH-1:0] st_b_q, st_b_d;
  logic [LAT-1:0][WIDTH:0]   st_sum_q, st_sum_d;
  logic [LAT-1:0]            st_c_q, st_c_d;
  logic [LAT-1:0][SelW-1:0]  st_n_q, st_n_d;
  logic [LAT-1:0]            st_hit_q, st_hit_d;
  logic [COUNT_W-1:0]        hit_count_q, hit_count_d;

  logic            stall;
  logic            out_fire;
  logic [SelW-1:0] n_sel;
  logic            hit0;

  // Stage inputs: slot 0 comes from the ports, slot s+1 from stage register s.
  logic [LAT:0][WIDTH-1:0] in_a, in_b;
  logic [LAT:0][WIDTH:0]   in_sum;
  logic [LAT:0]            in_c, in_v, in_h;
  logic [LAT:0][SelW-1:0]  in_n;
  logic                    unused_tail;

  assign stall    = st_valid_q[LAT-1] & ~out_ready_i;
  assign out_fire = st_valid_q[LAT-1] & out_ready_i;

  assign in_ready_o   = ~stall;
  assign out_valid_o  = st_valid_q[LAT-1];
  assign sum_o        = st_sum_q[LAT-1];
  assign approx_hit_o = st_hit_q[LAT-1];
  assign hit_count_o  = hit_count_q;

  assign n_sel = (inacc_sel_i > SelW'(NMax)) ? SelW'(NMax) : inacc_sel_i;

  // Any overlapping 1s in the low k bits mean OR may have dropped a carry.
  always_comb begin
    hit0 = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i < 4 * int'(n_sel)) begin
        hit0 = hit0 | (a_i[i] & b_i[i]);
      end
    end
  end

  assign in_a   = {st_a_q, a_i};
  assign in_b   = {st_b_q, b_i};
  assign in_sum = {st_sum_q, {(WIDTH + 1){1'b0}}};
  assign in_c   = {st_c_q, 1'b0};
  assign in_v   = {st_valid_q, in_valid_i};
  assign in_h   = {st_hit_q, hit0};
  assign in_n   = {st_n_q, n_sel};

  // Slot LAT only exists to make the slicing uniform.
  assign unused_tail = ^{in_a[LAT], in_b[LAT], in_sum[LAT], in_c[LAT], in_v[LAT],
                         in_h[LAT], in_n[LAT]};

  always_comb begin
    int gi;
    st_valid_d = in_v[LAT-1:0];
    st_a_d     = in_a[LAT-1:0];
    st_b_d     = in_b[LAT-1:0];
    st_sum_d   = in_sum[LAT-1:0];
    st_c_d     = in_c[LAT-1:0];
    st_n_d     = in_n[LAT-1:0];
    st_hit_d   = in_h[LAT-1:0];
    gi         = 0;
    for (int s = 0; s < int'(LAT); s++) begin
      for (int j = 0; j < int'(GPS); j++) begin
        gi = s * int'(GPS) + j;
        if (gi < int'(G)) begin
          if (gi < int'(st_n_d[s])) begin
            st_sum_d[s][4*gi +: 4] = st_a_d[s][4*gi +: 4] | st_b_d[s][4*gi +: 4];
            // The top inexact bit pair predicts the carry into the first exact group.
            st_c_d[s] = (gi == int'(st_n_d[s]) - 1) ?
                        (st_a_d[s][4*gi+3] & st_b_d[s][4*gi+3]) : 1'b0;
          end else begin
            {st_c_d[s], st_sum_d[s][4*gi +: 4]} =
                cla4(st_a_d[s][4*gi +: 4], st_b_d[s][4*gi +: 4], st_c_d[s]);
          end
        end
      end
      st_sum_d[s][WIDTH] = st_c_d[s];
    end
  end

  always_comb begin
    hit_count_d = hit_count_q;
    if (clr_count_i) begin
      hit_count_d = '0;
    end else if (out_fire && st_hit_q[LAT-1] && (hit_count_q != {COUNT_W{1'b1}})) begin
      hit_count_d = hit_count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_valid_q  <= '0;
      st_a_q      <= '0;
      st_b_q      <= '0;
      st_sum_q    <= '0;
      st_c_q      <= '0;
      st_n_q      <= '0;
      st_hit_q    <= '0;
      hit_count_q <= '0;
    end else begin
      if (!stall) begin
        st_valid_q <= st_valid_d;
        st_a_q     <= st_a_d;
        st_b_q     <= st_b_d;
        st_sum_q   <= st_sum_d;
        st_c_q     <= st_c_d;
        st_n_q     <= st_n_d;
        st_hit_q   <= st_hit_d;
      end
      hit_count_q <= hit_count_d;
    end
  end

endmodule

// File: tb/tb_heaa_pipe_adder.sv
// Self-checking bench for heaa_pipe_adder (WIDTH=32, MAX_INACC=16, GPS=2, COUNT_W=4).
// Expected results come from an arithmetic model: OR on the low k bits, a plain
// integer add of the shifted high parts with the predicted carry, and a saturating
// counter updated on each delivery.
module tb_heaa_pipe_adder;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] sum;
  logic        approx_hit;
  logic [3:0]  hit_count;
  logic        clr;

  heaa_pipe_adder #(
    .WIDTH    (32),
    .MAX_INACC(16),
    .GPS      (2),
    .COUNT_W  (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .inacc_sel_i (sel),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .approx_hit_o(approx_hit),
    .hit_count_o (hit_count),
    .clr_count_i (clr)
  );

  always #5 clk = ~clk;

  logic [33:0] exp_q[$];
  int          acc_q[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          exp_cnt = 0;
  int          n_out = 0;
  bit          lat_chk = 1'b0;
  bit          prev_stall = 1'b0;
  bit          in_fire;
  logic [32:0] held_sum;
  logic        held_hit;
  logic [32:0] last_sum;
  logic        last_hit;

  // Reference: {approx_hit, sum[32:0]}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [2:0] s);
    int          n;
    int          k;
    logic [63:0] mask, low, hi, full;
    logic        cin;
    logic        hit;
    n    = (s > 3'd4) ? 4 : int'(s);
    k    = 4 * n;
    mask = (64'd1 << k) - 64'd1;
    low  = ({32'd0, x} | {32'd0, y}) & mask;
    cin  = (k > 0) ? (x[k-1] & y[k-1]) : 1'b0;
    hi   = ({32'd0, x} >> k) + ({32'd0, y} >> k) + {63'd0, cin};
    full = (hi << k) | low;
    hit  = ({32'd0, x & y} & mask) != 64'd0;
    return {hit, full[32:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: sample away from the edge, score transfers, advance the edge.
  task automatic tick();
    logic        out_fire;
    logic [33:0] e;
    int          acc;
    #1;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (out_valid && !out_ready) begin
      check("in_ready_stall", in_ready, 0);
      if (prev_stall) begin
        check("sum_hold", sum, held_sum);
        check("hit_hold", approx_hit, held_hit);
      end
      prev_stall = 1'b1;
      held_sum   = sum;
      held_hit   = approx_hit;
    end else begin
      prev_stall = 1'b0;
    end
    e = '0;
    if (out_fire) begin
      check("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        acc = acc_q.pop_front();
        check("sum", sum, e[32:0]);
        check("approx_hit", approx_hit, e[33]);
        if (lat_chk) check("latency", cyc - acc, LAT);
      end
      last_sum = sum;
      last_hit = approx_hit;
      n_out++;
    end
    if (clr) exp_cnt = 0;
    else if (out_fire && e[33] && exp_cnt < 15) exp_cnt++;
    if (in_fire) begin
      exp_q.push_back(model(a, b, sel));
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    check("hit_count", hit_count, exp_cnt);
  endtask

  task automatic drain();
    int guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && guard < 60) begin
      tick();
      guard++;
    end
    check("drained", exp_q.size(), 0);
  endtask

  task automatic send_one(input logic [31:0] x, input logic [31:0] y, input logic [2:0] s);
    a        = x;
    b        = y;
    sel      = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int sent;
    int k;
    int guard;
    int out_before;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    a = '0; b = '0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_approx_hit", approx_hit, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    out_ready = 1'b1;

    // Directed cases with fixed expected values.
    lat_chk = 1'b1;
    send_one(32'hFFFF_FFFF, 32'h0000_0001, 3'd0);
    check("exact_sum", last_sum, 33'h1_0000_0000);
    check("exact_hit", last_hit, 0);
    send_one(32'h0000_0800, 32'h0000_0800, 3'd3);
    check("pred_carry_sum", last_sum, 33'h0_0000_1800);
    check("pred_carry_hit", last_hit, 1);
    send_one(32'h0000_0FFF, 32'h0000_0001, 3'd3);
    check("no_carry_sum", last_sum, 33'h0_0000_0FFF);
    check("no_carry_hit", last_hit, 1);
    send_one(32'h0000_FFFF, 32'h0000_FFFF, 3'd7);
    check("clamp_sum", last_sum, 33'h0_0001_FFFF);
    check("clamp_hit", last_hit, 1);

    // Random stream with a 6-cycle output stall in the middle.
    lat_chk    = 1'b0;
    out_before = n_out;
    sent = 0; k = 0;
    a = $urandom; b = $urandom; sel = 3'($urandom_range(0, 7));
    while (sent < 20 && k < 200) begin
      in_valid  = 1'b1;
      out_ready = !(k >= 8 && k < 14);
      tick();
      if (in_fire) begin
        sent++;
        a = $urandom; b = $urandom; sel = 3'($urandom_range(0, 7));
      end
      k++;
    end
    drain();
    check("stream_count", n_out - out_before, 20);

    // Saturation after 17 hits, then clear on the same edge as a hit delivery.
    lat_chk = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    a = 32'h1; b = 32'h1; sel = 3'd1;
    in_valid = 1'b1;
    repeat (17) tick();
    drain();
    check("hit_count_sat", hit_count, 15);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 10) begin
      tick();
      guard++;
    end
    check("wait_out_valid", out_valid, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_wins", hit_count, 0);

    // Reset with three transactions in flight.
    send_one(32'h0000_0003, 32'h0000_0001, 3'd1);
    check("pre_reset_count", hit_count, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'hA000_0000 + i; b = 32'h0500_0000; sel = 3'd2;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_hit_count", hit_count, 0);
    exp_q.delete();
    acc_q.delete();
    exp_cnt    = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_one(32'h1234_5678, 32'h1111_1111, 3'd0);
    check("post_rst_sum", last_sum, 33'h0_2345_6789);
    out_before = n_out;
    repeat (8) tick();
    check("no_stale_results", n_out - out_before, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
